// File: rtl/prefetch_unit.sv
// prefetch_unit: instruction fetch front end of the milano core.
// Owns the fetch PC and issues req/gnt/rvalid transactions to instruction RAM.
// Returned words are queued with their addresses in a small FIFO and presented
// one per cycle to the IF/ID register. Redirects from EX flush the FIFO and
// cause in-flight responses to be discarded.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   stall_from_ctrl_i      hold the presented instruction (no pop)
//   jump_flag_i/addr_i     redirect fetch; target bits [1:0] forced to zero
//   instr_req_o/addr_o     memory request and its address
//   instr_gnt_i            request accepted when req && gnt
//   instr_rvalid_i/rdata_i in-order memory responses
//   instr_rdata_o          instruction to IF/ID (NOP_INSTR when none valid)
//   instr_addr_if_o        address of instr_rdata_o (0 when none valid)
//   instr_valid_o          FIFO head valid
module prefetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_from_ctrl_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic [31:0] instr_rdata_o,
  output logic [31:0] instr_addr_if_o,
  output logic        instr_valid_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int unsigned CNT_W = (FIFO_DEPTH > 3) ? 3 : 2;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  // Registered state
  logic              run_q;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic              req_hold_q, req_hold_d;
  logic [1:0]        out_q, out_d;
  logic [1:0]        disc_q, disc_d;
  logic              redir_pend_q, redir_pend_d;
  logic [31:0]       redir_addr_q, redir_addr_d;
  logic [31:0]       tag_q [2];
  logic              tag_wp_q, tag_rp_q;
  logic [31:0]       fifo_addr_q [FIFO_DEPTH];
  logic [31:0]       fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wp_q, rp_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              gnt_acc, rsp_acc, push, pop, req_open;
  logic [CNT_W-1:0]  eff_cnt;
  logic [CNT_W:0]    reserved;
  logic [31:0]       jump_tgt;
  logic              unused_jump_lsbs;

  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign jump_tgt         = {jump_addr_i[31:2], 2'b00};
  assign unused_jump_lsbs = ^jump_addr_i[1:0];

  assign gnt_acc = instr_req_o && instr_gnt_i;
  assign rsp_acc = instr_rvalid_i && (out_q != 2'd0);
  assign pop     = instr_valid_o && !stall_from_ctrl_i;
  assign push    = rsp_acc && (disc_q == 2'd0) && !jump_flag_i;

  // A slot freed by this cycle's pop may be reserved by a new request, which
  // is what sustains one instruction per cycle with a 2-entry FIFO.
  assign eff_cnt  = cnt_q - CNT_W'(pop);
  assign reserved = {1'b0, eff_cnt} + (CNT_W + 1)'(out_q);
  assign req_open = run_q && (out_q < 2'd2) && (reserved < DEPTH_C);

  assign instr_req_o  = req_hold_q || req_open;
  assign instr_addr_o = fetch_pc_q;

  assign instr_valid_o   = (cnt_q != '0);
  assign instr_rdata_o   = instr_valid_o ? fifo_data_q[rp_q] : NOP_INSTR;
  assign instr_addr_if_o = instr_valid_o ? fifo_addr_q[rp_q] : '0;

  always_comb begin
    out_d        = out_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};
    req_hold_d   = instr_req_o && !instr_gnt_i;
    fetch_pc_d   = fetch_pc_q;
    disc_d       = disc_q;
    redir_pend_d = redir_pend_q;
    redir_addr_d = redir_addr_q;

    if (rsp_acc && (disc_q != 2'd0)) begin
      disc_d = disc_q - 2'd1;
    end

    if (gnt_acc) begin
      if (redir_pend_q) begin
        // The held request went to the stale PC: drop its data, then jump.
        fetch_pc_d   = redir_addr_q;
        redir_pend_d = 1'b0;
        disc_d       = disc_d + 2'd1;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end

    if (jump_flag_i) begin
      disc_d = out_d;
      if (instr_req_o && !instr_gnt_i) begin
        // A raised request cannot be retracted; park the target until gnt.
        redir_pend_d = 1'b1;
        redir_addr_d = jump_tgt;
      end else begin
        fetch_pc_d   = jump_tgt;
        redir_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_q        <= 1'b0;
      fetch_pc_q   <= BOOT_ADDR;
      req_hold_q   <= 1'b0;
      out_q        <= '0;
      disc_q       <= '0;
      redir_pend_q <= 1'b0;
      redir_addr_q <= '0;
      tag_wp_q     <= 1'b0;
      tag_rp_q     <= 1'b0;
      wp_q         <= '0;
      rp_q         <= '0;
      cnt_q        <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        tag_q[i] <= '0;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      run_q        <= 1'b1;
      fetch_pc_q   <= fetch_pc_d;
      req_hold_q   <= req_hold_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
      redir_pend_q <= redir_pend_d;
      redir_addr_q <= redir_addr_d;

      if (gnt_acc) begin
        tag_q[tag_wp_q] <= instr_addr_o;
        tag_wp_q        <= ~tag_wp_q;
      end
      if (rsp_acc) begin
        tag_rp_q <= ~tag_rp_q;
      end

      if (push) begin
        fifo_addr_q[wp_q] <= tag_q[tag_rp_q];
        fifo_data_q[wp_q] <= instr_rdata_i;
      end

      if (jump_flag_i) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) wp_q <= inc_ptr(wp_q);
        if (pop)  rp_q <= inc_ptr(rp_q);
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_unit.sv
module tb_prefetch_unit;

  logic        clk;
  logic        rst_ni;
  logic        stall;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        gnt_en;
  logic        rsp_en;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_if_o;
  logic        instr_valid_o;

  int checks;
  int failures;

  prefetch_unit #(
    .BOOT_ADDR (32'h0000_0080),
    .FIFO_DEPTH(2),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .stall_from_ctrl_i(stall),
    .jump_flag_i      (jump_flag),
    .jump_addr_i      (jump_addr),
    .instr_req_o      (instr_req_o),
    .instr_addr_o     (instr_addr_o),
    .instr_gnt_i      (gnt_en),
    .instr_rvalid_i   (mem_rvalid),
    .instr_rdata_i    (mem_rdata),
    .instr_rdata_o    (instr_rdata_o),
    .instr_addr_if_o  (instr_addr_if_o),
    .instr_valid_o    (instr_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: in-order, returns the address as data one cycle after the grant
  // when rsp_en is set; otherwise granted addresses wait in the queue.
  logic [31:0] mq [$];
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mq.delete();
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if (instr_req_o && gnt_en) mq.push_back(instr_addr_o);
      if (rsp_en && (mq.size() > 0)) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mq.pop_front();
      end else begin
        mem_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_ni    = 1'b0;
    stall     = 1'b0;
    jump_flag = 1'b0;
    jump_addr = '0;
    gnt_en    = 1'b1;
    rsp_en    = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", instr_req_o, 32'd0);
    chk("rst_addr", instr_addr_o, 32'h80);
    chk("rst_valid", instr_valid_o, 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'h13);
    chk("rst_addr_if", instr_addr_if_o, 32'd0);

    @(negedge clk);
    rst_ni = 1'b1;

    // Streaming, cycles 1..6: sequential addresses, valid from cycle 3
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      chk("stream_req", instr_req_o, 32'd1);
      chk("stream_addr", instr_addr_o, 32'h80 + 32'(4 * i));
      if (i >= 2) begin
        chk("stream_valid", instr_valid_o, 32'd1);
        chk("stream_rdata", instr_rdata_o, 32'h80 + 32'(4 * (i - 2)));
        chk("stream_addr_if", instr_addr_if_o, 32'h80 + 32'(4 * (i - 2)));
      end else begin
        chk("stream_nvalid", instr_valid_o, 32'd0);
      end
    end

    // Stall for 5 cycles: head frozen at 0x90, request withheld
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      stall = 1'b1;
      #1;
      chk("stall_valid", instr_valid_o, 32'd1);
      chk("stall_rdata", instr_rdata_o, 32'h90);
      chk("stall_addr_if", instr_addr_if_o, 32'h90);
      chk("stall_req", instr_req_o, 32'd0);
    end

    // Release: no loss, no duplicate
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      stall = 1'b0;
      #1;
      chk("unstall_valid", instr_valid_o, 32'd1);
      chk("unstall_rdata", instr_rdata_o, 32'h90 + 32'(4 * j));
      if (j == 0) chk("unstall_addr", instr_addr_o, 32'h98);
    end

    // Build up two outstanding requests by holding responses
    @(negedge clk);                      // cycle 16
    rsp_en = 1'b0;
    #1;
    chk("hold_rdata0", instr_rdata_o, 32'hA0);
    @(negedge clk);                      // cycle 17
    #1;
    chk("hold_rdata1", instr_rdata_o, 32'hA4);
    chk("hold_addr1", instr_addr_o, 32'hAC);
    @(negedge clk);                      // cycle 18: outstanding = 2
    jump_flag = 1'b1;
    jump_addr = 32'h0000_1003;
    rsp_en    = 1'b1;
    #1;
    chk("out2_req", instr_req_o, 32'd0);
    chk("out2_valid", instr_valid_o, 32'd0);
    @(negedge clk);                      // cycle 19
    jump_flag = 1'b0;
    #1;
    chk("j1_valid19", instr_valid_o, 32'd0);
    chk("j1_req19", instr_req_o, 32'd0);
    @(negedge clk);                      // cycle 20
    #1;
    chk("j1_req20", instr_req_o, 32'd1);
    chk("j1_addr20", instr_addr_o, 32'h1000);
    chk("j1_valid20", instr_valid_o, 32'd0);
    @(negedge clk);                      // cycle 21
    #1;
    chk("j1_valid21", instr_valid_o, 32'd0);
    chk("j1_addr21", instr_addr_o, 32'h1004);
    @(negedge clk);                      // cycle 22: redirect with response in flight
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0040;
    #1;
    chk("j1_valid22", instr_valid_o, 32'd1);
    chk("j1_rdata22", instr_rdata_o, 32'h1000);
    chk("j1_addr_if22", instr_addr_if_o, 32'h1000);
    chk("j2_addr22", instr_addr_o, 32'h1008);

    // Redirect while the 0x40 request is held ungranted
    @(negedge clk);                      // cycle 23
    jump_flag = 1'b0;
    gnt_en    = 1'b0;
    #1;
    chk("j2_valid23", instr_valid_o, 32'd0);
    chk("j2_req23", instr_req_o, 32'd1);
    chk("j2_addr23", instr_addr_o, 32'h40);
    @(negedge clk);                      // cycle 24
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0200;
    #1;
    chk("pend_addr24", instr_addr_o, 32'h40);
    @(negedge clk);                      // cycle 25
    jump_flag = 1'b0;
    #1;
    chk("pend_req25", instr_req_o, 32'd1);
    chk("pend_addr25", instr_addr_o, 32'h40);
    @(negedge clk);                      // cycle 26
    gnt_en = 1'b1;
    #1;
    chk("pend_addr26", instr_addr_o, 32'h40);
    @(negedge clk);                      // cycle 27
    #1;
    chk("pend_tgt_req", instr_req_o, 32'd1);
    chk("pend_tgt_addr", instr_addr_o, 32'h200);
    chk("pend_valid27", instr_valid_o, 32'd0);
    @(negedge clk);                      // cycle 28: 0x40 data dropped
    #1;
    chk("pend_valid28", instr_valid_o, 32'd0);
    @(negedge clk);                      // cycle 29
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFF8;
    #1;
    chk("pend_valid29", instr_valid_o, 32'd1);
    chk("pend_rdata29", instr_rdata_o, 32'h200);

    // PC wrap
    @(negedge clk);                      // cycle 30
    jump_flag = 1'b0;
    #1;
    chk("wrap_addr0", instr_addr_o, 32'hFFFF_FFF8);
    @(negedge clk);                      // cycle 31
    #1;
    chk("wrap_addr1", instr_addr_o, 32'hFFFF_FFFC);
    @(negedge clk);                      // cycle 32
    #1;
    chk("wrap_addr2", instr_addr_o, 32'h0000_0000);
    chk("wrap_rdata2", instr_rdata_o, 32'hFFFF_FFF8);
    @(negedge clk);                      // cycle 33
    rsp_en = 1'b0;
    #1;
    chk("wrap_rdata3", instr_rdata_o, 32'hFFFF_FFFC);
    @(negedge clk);                      // cycle 34
    #1;
    chk("wrap_rdata4", instr_rdata_o, 32'h0);
    chk("wrap_addr_if4", instr_addr_if_o, 32'h0);
    chk("wrap_valid4", instr_valid_o, 32'd1);
    @(negedge clk);                      // cycle 35: outstanding = 2
    #1;
    chk("pre_rst_req", instr_req_o, 32'd0);
    chk("pre_rst_addr", instr_addr_o, 32'hC);

    // Asynchronous reset mid-stream
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_req", instr_req_o, 32'd0);
    chk("arst_addr", instr_addr_o, 32'h80);
    chk("arst_valid", instr_valid_o, 32'd0);
    chk("arst_rdata", instr_rdata_o, 32'h13);
    chk("arst_addr_if", instr_addr_if_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    rsp_en = 1'b1;
    @(negedge clk);
    #1;
    chk("restart_req", instr_req_o, 32'd1);
    chk("restart_addr0", instr_addr_o, 32'h80);
    @(negedge clk);
    #1;
    chk("restart_addr1", instr_addr_o, 32'h84);
    chk("restart_nvalid", instr_valid_o, 32'd0);
    @(negedge clk);
    #1;
    chk("restart_valid", instr_valid_o, 32'd1);
    chk("restart_rdata", instr_rdata_o, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
